// File: rtl/bcd_add_seq.sv
// bcd_add_seq: multi-digit BCD adder sequencer.
// One shared 4-bit digit adder with decimal correction processes the operands
// one digit per clock, least significant digit first, and pulses done when the
// full sum is ready.
// Optional feature: define BCD_SUB_EN to add a 'sub' input that selects
// A - B in ten's complement (nines complement of B plus an initial carry).
module bcd_add_seq #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
`ifdef BCD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned W    = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;

    logic              sub_active;
    logic              sub_start;
    logic [3:0]        a_dig;
    logic [3:0]        b_dig;
    logic [3:0]        b_eff;
    logic [4:0]        raw;
    logic              ge10;
    logic [3:0]        dig_out;
    logic              dig_bad;

`ifdef BCD_SUB_EN
    logic              sub_q, sub_d;

    // Operation mode register, captured together with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end

    // Latch the mode only when a new operation is accepted.
    always_comb begin
        sub_d = sub_q;
        if (state_q == StIdle && start) begin
            sub_d = sub;
        end
    end

    assign sub_active = sub_q;
    assign sub_start  = sub;
`else
    assign sub_active = 1'b0;
    assign sub_start  = 1'b0;
`endif

    // Shared digit adder: select digit idx, add with carry, apply +6 correction.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        // Nines complement wraps mod 16 for invalid digits; err flags that case.
        b_eff   = sub_active ? (4'd9 - b_dig) : b_dig;
        raw     = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
        ge10    = raw[4] | (raw[3] & (raw[2] | raw[1]));
        dig_out = ge10 ? (raw[3:0] + 4'd6) : raw[3:0];
        dig_bad = (a_dig > 4'd9) | (b_dig > 4'd9);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept in idle, one digit per cycle in add, one-cycle done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    idx_d   = '0;
                    carry_d = sub_start;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[4*i +: 4] = dig_out;
                    end
                end
                carry_d = ge10;
                err_d   = err_q | dig_bad;
                if (idx_q == IdxW'(DIGITS - 1)) begin
                    cout_d  = ge10;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_add_seq.sv
// tb_bcd_add_seq: self-checking bench for bcd_add_seq with DIGITS = 4.
// Reference results come from decimal integer arithmetic on the operands.
module tb_bcd_add_seq;

    localparam int D = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   a;
    logic [15:0]   b;
`ifdef BCD_SUB_EN
    logic          sub;
`endif
    logic          busy;
    logic          done;
    logic [15:0]   sum;
    logic          cout;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    bcd_add_seq #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef BCD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        int m = 1;
        for (int i = 0; i < D; i++) begin
            r = r + int'(v[4*i +: 4]) * m;
            m = m * 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Decimal reference: A+B, or A + (10^D - 1 - B) + 1 for subtraction.
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic sv);
        int t;
        if (sv) t = bcd2int(av) + (9999 - bcd2int(bv)) + 1;
        else    t = bcd2int(av) + bcd2int(bv);
        return {int2bcd(t % 10000), (t >= 10000), 1'b0};
    endfunction

    // Issue one operation from an idle cycle; returns the values seen at done and
    // the number of edges from the accepting edge to done (-1 on timeout).
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          output logic [17:0] res, output int lat);
        a = av;
        b = bv;
`ifdef BCD_SUB_EN
        sub = sv;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
        res = {sum, cout, err};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({busy, done, sum, cout, err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", {busy, done, sum, cout, err});
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [17:0] res;
        int lat;
        run_op(16'h0058, 16'h0067, 1'b0, res, lat);
        n_cmp++;
        if (lat !== D) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d", lat, D);
        end
        n_cmp++;
        if (res !== {16'h0125, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got %h want %h", res, {16'h0125, 1'b0, 1'b0});
        end
        // Back in idle: busy low, result still held.
        n_cmp++;
        if ({busy, done, sum} !== {2'b00, 16'h0125}) begin
            n_fail++;
            $display("FAIL basic_hold: got %h want %h", {busy, done, sum}, {2'b00, 16'h0125});
        end
    endtask

    task automatic test_carry();
        logic [17:0] res;
        int lat;
        run_op(16'h9999, 16'h0001, 1'b0, res, lat);
        n_cmp++;
        if (res !== {16'h0000, 1'b1, 1'b0} || lat !== D) begin
            n_fail++;
            $display("FAIL carry_wrap: got %h lat %0d want %h lat %0d", res, lat,
                     {16'h0000, 1'b1, 1'b0}, D);
        end
        run_op(16'h0999, 16'h0001, 1'b0, res, lat);
        n_cmp++;
        if (res !== {16'h1000, 1'b0, 1'b0} || lat !== D) begin
            n_fail++;
            $display("FAIL carry_ripple: got %h lat %0d want %h lat %0d", res, lat,
                     {16'h1000, 1'b0, 1'b0}, D);
        end
    endtask

    task automatic test_err();
        logic [17:0] res;
        int lat;
        // Digit 0 = 10: raw 10 corrects to 0 with carry, so sum = 0x0010.
        run_op(16'h000A, 16'h0000, 1'b0, res, lat);
        n_cmp++;
        if (res !== {16'h0010, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL err_set: got %h want %h", res, {16'h0010, 1'b0, 1'b1});
        end
        run_op(16'h0012, 16'h0034, 1'b0, res, lat);
        n_cmp++;
        if (res !== {16'h0046, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL err_clear: got %h want %h", res, {16'h0046, 1'b0, 1'b0});
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        logic early_idle = 1'b0;
        logic [17:0] res = '0;
        a = 16'h1234;
        b = 16'h4321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 16'h9999;
        b = 16'h9999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                n_done++;
                res = {sum, cout, err};
            end
            if (!busy && n_done == 0) early_idle = 1'b1;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d want 1", n_done);
        end
        n_cmp++;
        if (early_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy: busy dropped before done (got %b want 0)", early_idle);
        end
        n_cmp++;
        if (res !== {16'h5555, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_result: got %h want %h", res, {16'h5555, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        logic [17:0] res;
        int lat;
        a = 16'h1234;
        b = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, sum, cout, err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got %h want 0", {busy, done, sum, cout, err});
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", n_done);
        end
        run_op(16'h0456, 16'h0544, 1'b0, res, lat);
        n_cmp++;
        if (res !== {16'h1000, 1'b0, 1'b0} || lat !== D) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got %h lat %0d want %h lat %0d", res, lat,
                     {16'h1000, 1'b0, 1'b0}, D);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] busy_v = '0;
        logic [11:0] done_v = '0;
        a = 16'h0005;
        b = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 12; k++) begin
            busy_v[k] = busy;
            done_v[k] = done;
            if (k == 11) start = 1'b0;
            if (k < 11) begin
                @(posedge clk);
                #1;
            end
        end
        n_cmp++;
        if (busy_v !== 12'b0111_1101_1111) begin
            n_fail++;
            $display("FAIL b2b_busy: got %b want %b", busy_v, 12'b0111_1101_1111);
        end
        n_cmp++;
        if (done_v !== 12'b0100_0001_0000) begin
            n_fail++;
            $display("FAIL b2b_done: got %b want %b", done_v, 12'b0100_0001_0000);
        end
        n_cmp++;
        if ({sum, cout, err} !== {16'h0010, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_result: got %h want %h", {sum, cout, err},
                     {16'h0010, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
    endtask

`ifdef BCD_SUB_EN
    task automatic test_sub();
        logic [17:0] res;
        int lat;
        run_op(16'h0100, 16'h0001, 1'b1, res, lat);
        n_cmp++;
        if (res !== {16'h0099, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_no_borrow: got %h want %h", res, {16'h0099, 1'b1, 1'b0});
        end
        run_op(16'h0001, 16'h0002, 1'b1, res, lat);
        n_cmp++;
        if (res !== {16'h9999, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h want %h", res, {16'h9999, 1'b0, 1'b0});
        end
    endtask
`endif

    task automatic test_random();
        logic [17:0] res;
        logic [17:0] exp;
        logic [15:0] av;
        logic [15:0] bv;
        logic sv;
        int lat;
        for (int n = 0; n < 24; n++) begin
            av = rand_bcd();
            bv = rand_bcd();
`ifdef BCD_SUB_EN
            sv = 1'($urandom_range(0, 1));
`else
            sv = 1'b0;
`endif
            exp = model(av, bv, sv);
            run_op(av, bv, sv, res, lat);
            n_cmp++;
            if (res !== exp || lat !== D) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h sub=%b got %h lat %0d want %h lat %0d",
                         n, av, bv, sv, res, lat, exp, D);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef BCD_SUB_EN
        sub   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_carry();
        test_err();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef BCD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_add_seq.md
Name: bcd_add_seq

Overview:
- Multi-digit BCD adder sequencer built around a single shared 4-bit digit adder and a ">= 10" decimal-correction detector.
- Processes operands one digit per clock, LSB digit first, applying +6 correction and decimal carry.
- Sits between the digit-entry/control logic and the BCD display path; accepts operands on a start handshake and returns a full BCD sum with done pulse.

Parameters:
- DIGITS, 4, number of BCD digits per operand (1..8).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD, same packing.
- busy  output  1  high from the accepting edge until return to IDLE.
- done  output  1  one-cycle pulse, result valid.
- sum  output  4*DIGITS  packed BCD result; held until next accepted start.
- cout  output  1  decimal carry out of the top digit.
- err  output  1  sticky flag: some input digit > 9 in current operation.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset, asynchronous, any state: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, internal operand regs, index and carry cleared. Reset mid-operation aborts with no done.
- States: IDLE, ADD, DONE.
- IDLE: on start=1 at an edge, latch a and b, carry=0, idx=0, clear sum, cout and err, busy=1, go ADD. start=0: stay.
- ADD: each edge processes digit idx.
  - raw = a_idx + b_idx + carry, 5 bits, range 0..19 for valid digits.
  - ge10 = raw[4] | (raw[3] & (raw[2] | raw[1])).
  - ge10=1: digit = (raw + 6) mod 16, carry=1. Otherwise digit = raw[3:0], carry=0.
  - Write digit into sum slot idx.
  - If a_idx > 9 or b_idx > 9, set err. Computation proceeds unchanged; the result is undefined but deterministic per the equations above.
  - idx = DIGITS-1: cout=final carry, go DONE. Otherwise idx+1.
- DONE: done=1 for exactly this cycle, busy=1. Next edge goes to IDLE with busy=0.
- Latency: done is high in the cycle following the DIGITS-th edge after the start-accepting edge. Total occupancy is DIGITS+1 cycles.
- start while busy (ADD or DONE) is ignored, not queued. start held high continuously re-triggers one cycle after return to IDLE.
- a and b may change after the accepting edge without effect.
- sum is visible as partially built during ADD. It is only guaranteed when done=1 and thereafter until the next accepted start.
- idx width is ceil(log2(DIGITS)), minimum 1 bit.

Optional Feature:
- Macro: BCD_SUB_EN.
- Defined: extra input port sub (1 bit), latched with operands on start.
  - sub=1: each b digit is replaced by its nines complement (9 - b_idx), and initial carry=1. Result is A - B in ten's complement.
  - cout=1 means no borrow (A >= B). cout=0 means borrow, and sum holds 10^DIGITS - (B - A).
  - err is evaluated on the original b digits.
- Not defined: no sub port, addition only, behaviour exactly as above.

Test Plan:
- DIGITS=4, a=0x0058, b=0x0067, pulse start -> done exactly 4 cycles after the accepting edge; sum=0x0125, cout=0, err=0.
- a=0x9999, b=0x0001 -> sum=0x0000, cout=1. Then a=0x0999, b=0x0001 -> sum=0x1000, cout=0.
- a=0x000A, b=0x0000 -> err=1 at done; next start with valid digits clears err to 0.
- Start, then pulse start again during ADD with different operands -> only the first result is produced, a single done pulse, busy stays high throughout.
- Deassert rst_n two cycles into ADD -> busy, done, sum, cout and err go 0 immediately; no done follows; a new start after release works normally.
- With BCD_SUB_EN defined:
  - sub=1, a=0x0100, b=0x0001 -> sum=0x0099, cout=1.
  - sub=1, a=0x0001, b=0x0002 -> sum=0x9999, cout=0.
